// File: rtl/elastic_buffer_pkg.sv
// Shared helpers for the elastic buffer: occupancy counter width and parameter sanity predicates.
package elastic_buffer_pkg;

    // Occupancy runs 0..depth inclusive, so it needs one more code point than the pointers.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit af_level_ok(input int af_level, input int depth);
        return (af_level >= 1) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/elastic_buffer.sv
// Valid/ready elastic buffer: DEPTH-entry FIFO with registered-only in_ready, almost_full and synchronous flush.
module elastic_buffer
    import elastic_buffer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("elastic_buffer: DEPTH must be a power of two and at least 2");
    end
    if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_af_level
        $error("elastic_buffer: AF_LEVEL must lie in 1..DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    // in_ready looks only at stored occupancy, so a full buffer refuses a push even when a pop frees a slot.
    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign out_data    = mem[rd_ptr];
    assign count       = count_q;
    assign almost_full = (count_q >= CW'(AF_LEVEL));

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is reset so out_data reads zero out of reset; flush deliberately leaves contents alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule
